// File: rtl/gate_ctrl_if.sv
// gate_ctrl_if: signal bundle between the SPI register write port / counter
// datapath and the gate_ctrl measurement sequencer.
//   cfg_we, cfg_data : gate-length register write strobe and data (16 b, ticks)
//   ovf_in           : carry out of the most significant BCD digit
//   cnt_clr, cnt_en  : clear and count enable to the BCD counter chain
//   latch            : one-cycle display latch strobe
//   busy, ovf, state : status and debug outputs
// slave is the sequencer side; master is the side that drives configuration.
interface gate_ctrl_if;
  logic        cfg_we;
  logic [15:0] cfg_data;
  logic        ovf_in;
  logic        cnt_clr;
  logic        cnt_en;
  logic        latch;
  logic        busy;
  logic        ovf;
  logic [2:0]  state;

  modport slave (
    input  cfg_we, cfg_data, ovf_in,
    output cnt_clr, cnt_en, latch, busy, ovf, state
  );

  modport master (
    output cfg_we, cfg_data, ovf_in,
    input  cnt_clr, cnt_en, latch, busy, ovf, state
  );
endinterface

// File: rtl/gate_ctrl.sv
// gate_ctrl: measurement sequencer for the gated signal counter.
// Runs clear -> count (gate) -> settle -> latch, repeating while the gate length
// register is nonzero.
//   clk     : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : gate_ctrl_if.slave (config write, overflow input, counter/display
//             controls, status)
// Parameters: PRESCALE clk cycles per gate tick (1..65535), SETTLE clk cycles of
// dead time before the latch (1..15).
// Optional feature: define GSC_GATE_OVF_EN to get a sticky overflow flag;
// otherwise ovf is tied low and ovf_in is ignored.
module gate_ctrl #(
  parameter int unsigned PRESCALE = 24000,
  parameter int unsigned SETTLE   = 4
) (
  input logic        clk,
  input logic        reset_n,
  gate_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StClear = 3'd1,
    StGate  = 3'd2,
    StHold  = 3'd3,
    StLatch = 3'd4
  } state_e;

  localparam logic [15:0] PreLoad    = 16'(PRESCALE - 1);
  localparam logic [3:0]  SettleLoad = 4'(SETTLE - 1);

  state_e      state_q, state_d;
  logic [15:0] len_q;
  logic [15:0] gcnt_q, gcnt_d;
  logic [15:0] pcnt_q, pcnt_d;
  logic [3:0]  scnt_q, scnt_d;

  // Length register accepts writes in every state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      len_q <= '0;
    end else if (bus.cfg_we) begin
      len_q <= bus.cfg_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      gcnt_q  <= '0;
      pcnt_q  <= '0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      gcnt_q  <= gcnt_d;
      pcnt_q  <= pcnt_d;
      scnt_q  <= scnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gcnt_d  = gcnt_q;
    pcnt_d  = pcnt_q;
    scnt_d  = scnt_q;
    case (state_q)
      StIdle: begin
        if (len_q != '0) state_d = StClear;
      end
      StClear: begin
        gcnt_d  = len_q;
        pcnt_d  = PreLoad;
        state_d = StGate;
      end
      StGate: begin
        if (bus.cfg_we) begin
          // A write mid-gate abandons this measurement without latching.
          state_d = (bus.cfg_data != '0) ? StClear : StIdle;
        end else if (pcnt_q == '0) begin
          pcnt_d = PreLoad;
          if (gcnt_q <= 16'd1) begin
            gcnt_d  = '0;
            scnt_d  = SettleLoad;
            state_d = StHold;
          end else begin
            gcnt_d = gcnt_q - 16'd1;
          end
        end else begin
          pcnt_d = pcnt_q - 16'd1;
        end
      end
      StHold: begin
        if (scnt_q == '0) begin
          state_d = StLatch;
        end else begin
          scnt_d = scnt_q - 4'd1;
        end
      end
      StLatch: begin
        // A write landing on the latch cycle decides whether to continue, so a
        // stop written here is honoured immediately.
        if (bus.cfg_we) begin
          state_d = (bus.cfg_data != '0) ? StClear : StIdle;
        end else begin
          state_d = (len_q != '0) ? StClear : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.cnt_clr = (state_q == StClear);
  assign bus.cnt_en  = (state_q == StGate);
  assign bus.latch   = (state_q == StLatch);
  assign bus.busy    = (state_q != StIdle);
  assign bus.state   = state_q;

`ifdef GSC_GATE_OVF_EN
  logic ovf_q;

  // Sticky through LATCH so the display can flag the overflow; CLEAR wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
    end else if (state_q == StClear) begin
      ovf_q <= 1'b0;
    end else if ((state_q == StGate || state_q == StHold) && bus.ovf_in) begin
      ovf_q <= 1'b1;
    end
  end

  assign bus.ovf = ovf_q;
`else
  logic unused_ovf_in;
  assign unused_ovf_in = bus.ovf_in;
  assign bus.ovf       = 1'b0;
`endif

endmodule
